// File: rtl/urv_defs.sv
// Shared definitions for the uRV instruction-memory Wishbone bridge.
package urv_defs;

    localparam int unsigned TAG_W = 30;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT
    } state_t;

    localparam logic [3:0] WB_SEL_WORD = 4'hf;

endpackage

// File: rtl/urv_wb_timeout.sv
// Bus-cycle watchdog: cleared on strobe acceptance, counts waiting cycles,
// flags the g_timeout-th waiting cycle and restarts from zero.
module urv_wb_timeout #(
    parameter int unsigned g_timeout = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(g_timeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_timeout - 1);

    logic [CNT_W-1:0] cnt;

    assign expire_c = en_i && (cnt == CNT_LAST);

    // Wait-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || load_i || expire_c) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/urv_imem_wb_bridge.sv
// Fetch-side instruction memory port served by a pipelined Wishbone master,
// with a one-word hold buffer answering repeated fetches of the same word.
module urv_imem_wb_bridge
    import urv_defs::*;
#(
    parameter int unsigned g_timeout = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    output logic        im_fault_o,
    input  logic        inv_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);

    state_t           state;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] buf_tag;
    logic [31:0]      buf_data;
    logic             buf_valid;

    logic [TAG_W-1:0] addr_tag_c;
    logic             hit_c;
    logic             same_c;
    logic             resp_c;
    logic             err_c;
    logic             ack_c;
    logic             tmo_c;
    logic             stb_take_c;

    assign addr_tag_c = im_addr_i[31:2];
    assign hit_c      = buf_valid && (buf_tag == addr_tag_c) && !inv_i;
    assign same_c     = (req_tag == addr_tag_c);
    assign stb_take_c = (state == REQ) && !wb_stall_i;
    // A response may land in the same cycle the strobe is accepted.
    assign resp_c     = (state == WAIT) || stb_take_c;
    assign err_c      = resp_c && (wb_err_i || tmo_c);
    assign ack_c      = resp_c && wb_ack_i && !err_c;

    assign wb_we_o  = 1'b0;
    assign wb_sel_o = WB_SEL_WORD;

    // Optional watchdog on the outstanding bus cycle.
    generate
        if (g_timeout > 0) begin : g_tmo
            urv_wb_timeout #(
                .g_timeout(g_timeout)
            ) u_tmo (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .load_i   (stb_take_c),
                .en_i     (state == WAIT),
                .expire_c (tmo_c)
            );
        end else begin : g_no_tmo
            assign tmo_c = 1'b0;
        end
    endgenerate

    // Bus FSM, hold buffer and fetch-side response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_adr_o   <= '0;
            req_tag    <= '0;
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= '0;
            im_valid_o <= 1'b0;
            im_data_o  <= '0;
            im_fault_o <= 1'b0;
        end else begin
            im_valid_o <= 1'b0;
            im_fault_o <= 1'b0;

            if (hit_c) begin
                im_valid_o <= 1'b1;
                im_data_o  <= buf_data;
            end

            if (inv_i) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!hit_c) begin
                        wb_adr_o <= {addr_tag_c, 2'b00};
                        req_tag  <= addr_tag_c;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                end
                default: state <= IDLE;
            endcase

            // Termination; the word is kept even if the fetch moved on.
            if (err_c) begin
                wb_cyc_o   <= 1'b0;
                state      <= IDLE;
                im_fault_o <= same_c;
            end else if (ack_c) begin
                wb_cyc_o <= 1'b0;
                state    <= IDLE;
                if (!inv_i) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= req_tag;
                    buf_data  <= wb_dat_i;
                    if (same_c) begin
                        im_valid_o <= 1'b1;
                        im_data_o  <= wb_dat_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_urv_imem_wb_bridge.sv
// Directed bench for urv_imem_wb_bridge; the slave is driven step by step.
module tb_urv_imem_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        im_fault_o;
    logic        inv_i;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int acc0;

    urv_imem_wb_bridge #(.g_timeout(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .im_addr_i  (im_addr_i),
        .im_data_o  (im_data_o),
        .im_valid_o (im_valid_o),
        .im_fault_o (im_fault_o),
        .inv_i      (inv_i),
        .wb_adr_o   (wb_adr_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    // Count strobes accepted by the slave.
    always @(posedge clk_i) begin
        if (wb_cyc_o && wb_stb_o && !wb_stall_i) accepts <= accepts + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; im_addr_i = 32'h0; inv_i = 1'b0;
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        tick(); tick();
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_valid", 32'(im_valid_o), 32'd0);
        chk("rst_data", im_data_o, 32'h0);
        chk("rst_fault", 32'(im_fault_o), 32'd0);
        chk("tie_we", 32'(wb_we_o), 32'd0);
        chk("tie_sel", 32'(wb_sel_o), 32'hf);

        // Cold fetch of address 0.
        rst_i = 1'b0;
        tick();
        chk("cold_cyc", 32'(wb_cyc_o), 32'd1);
        chk("cold_stb", 32'(wb_stb_o), 32'd1);
        chk("cold_adr", wb_adr_o, 32'h0);
        tick();
        chk("cold_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("cold_wait_valid", 32'(im_valid_o), 32'd0);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0013;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        chk("cold_valid", 32'(im_valid_o), 32'd1);
        chk("cold_data", im_data_o, 32'h0000_0013);
        chk("cold_cyc_end", 32'(wb_cyc_o), 32'd0);
        tick();
        chk("cold_one_cycle", 32'(accepts), 32'd1);
        chk("cold_hit", 32'(im_valid_o), 32'd1);

        // Fetch 0x100, then hold it for 10 cycles.
        im_addr_i = 32'h100;
        tick();
        chk("held_adr", wb_adr_o, 32'h100);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0093;
        tick();
        wb_ack_i = 1'b0;
        chk("held_fwd", im_data_o, 32'h0000_0093);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("held_valid", 32'(im_valid_o), 32'd1);
            chk("held_data", im_data_o, 32'h0000_0093);
            chk("held_cyc", 32'(wb_cyc_o), 32'd0);
        end

        // Branch away from 0x200 while its request is outstanding.
        im_addr_i = 32'h200;
        tick();
        chk("br_adr200", wb_adr_o, 32'h200);
        tick();
        im_addr_i = 32'h400;
        tick();
        chk("br_wait_valid", 32'(im_valid_o), 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h00a0_0093;
        tick();
        wb_ack_i = 1'b0;
        chk("br_no_fwd", 32'(im_valid_o), 32'd0);
        chk("br_cyc_end", 32'(wb_cyc_o), 32'd0);
        tick();
        chk("br_adr400", wb_adr_o, 32'h400);
        chk("br_stb400", 32'(wb_stb_o), 32'd1);
        acc0 = accepts;
        im_addr_i = 32'h200;
        tick();
        chk("br_hit200_valid", 32'(im_valid_o), 32'd1);
        chk("br_hit200_data", im_data_o, 32'h00a0_0093);
        chk("br_hit_no_new", 32'(accepts - acc0), 32'd1);
        im_addr_i = 32'h400; wb_ack_i = 1'b1; wb_dat_i = 32'h0040_0113;
        tick();
        wb_ack_i = 1'b0;
        chk("br_fwd400", im_data_o, 32'h0040_0113);
        chk("br_valid400", 32'(im_valid_o), 32'd1);

        // Slave stalls the strobe for three cycles.
        im_addr_i = 32'h500; wb_stall_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_stb", 32'(wb_stb_o), 32'd1);
            chk("stall_adr", wb_adr_o, 32'h500);
        end
        wb_stall_i = 1'b0;
        tick();
        chk("stall_stb_drop", 32'(wb_stb_o), 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0050_0193;
        tick();
        wb_ack_i = 1'b0;
        chk("stall_valid", 32'(im_valid_o), 32'd1);
        chk("stall_data", im_data_o, 32'h0050_0193);

        // Slave never answers: timeout after 8 cycles, then retry.
        im_addr_i = 32'h600;
        tick();
        tick();
        chk("tmo_accepted", 32'(wb_stb_o), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("tmo_quiet", 32'(im_fault_o), 32'd0);
        end
        tick();
        chk("tmo_fault", 32'(im_fault_o), 32'd1);
        chk("tmo_cyc_drop", 32'(wb_cyc_o), 32'd0);
        tick();
        chk("tmo_pulse", 32'(im_fault_o), 32'd0);
        chk("tmo_retry_cyc", 32'(wb_cyc_o), 32'd1);
        chk("tmo_retry_adr", wb_adr_o, 32'h600);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0060_0213;
        tick();
        wb_ack_i = 1'b0;
        chk("tmo_retry_data", im_data_o, 32'h0060_0213);

        // Invalidate together with ack: nothing stored, nothing forwarded.
        im_addr_i = 32'h700;
        tick();
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0070_0293; inv_i = 1'b1;
        tick();
        wb_ack_i = 1'b0; inv_i = 1'b0;
        chk("inv_ack_valid", 32'(im_valid_o), 32'd0);
        chk("inv_ack_cyc", 32'(wb_cyc_o), 32'd0);
        tick();
        chk("inv_refetch_cyc", 32'(wb_cyc_o), 32'd1);
        chk("inv_refetch_adr", wb_adr_o, 32'h700);
        chk("inv_refetch_valid", 32'(im_valid_o), 32'd0);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("inv_fill_data", im_data_o, 32'h0070_0293);
        // Invalidate together with a hit.
        inv_i = 1'b1;
        tick();
        inv_i = 1'b0;
        chk("inv_hit_valid", 32'(im_valid_o), 32'd0);
        chk("inv_hit_miss", 32'(wb_cyc_o), 32'd1);
        tick();
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("inv_hit_refill", 32'(im_valid_o), 32'd1);

        // Reset during WAIT, then a stray ack.
        im_addr_i = 32'h800;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstw_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rstw_stb", 32'(wb_stb_o), 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hdead_beef;
        tick();
        wb_ack_i = 1'b0;
        chk("rstw_stray_valid", 32'(im_valid_o), 32'd0);
        chk("rstw_new_adr", wb_adr_o, 32'h800);
        tick();
        tick();
        chk("rstw_still_none", 32'(im_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
